// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: instruction memory, branch predictor, hazard/redirect
// controls and the IF/ID register outputs of fetch_pc_unit.
interface fetch_pc_unit_if;
  logic [31:0] imem_addr_o;
  logic [31:0] instr_i;
  logic        imem_stall_i;
  logic [31:0] branch_pc_o;
  logic        pred_take_i;
  logic [31:0] pred_dest_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_pred_taken_o;
  logic [31:0] if_pred_target_o;

  // Fetch unit side
  modport master (
    output imem_addr_o, branch_pc_o,
    output if_valid_o, if_pc_o, if_instr_o, if_pred_taken_o, if_pred_target_o,
    input  instr_i, imem_stall_i, pred_take_i, pred_dest_i,
    input  stall_i, redirect_i, redirect_pc_i
  );

  // Memory / predictor / pipeline side
  modport slave (
    input  imem_addr_o, branch_pc_o,
    input  if_valid_o, if_pc_o, if_instr_o, if_pred_taken_o, if_pred_target_o,
    output instr_i, imem_stall_i, pred_take_i, pred_dest_i,
    output stall_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: keeps the program counter, predicts next PC from the fetched
// word (JAL always, conditional branches via the predictor), waits out busy
// instruction memory and applies redirects from EX.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic        USE_BTB_TARGET = 1'b0
) (
  input logic            clk,
  input logic            rst,
  fetch_pc_unit_if.master bus
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_WAIT_REDIR} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pending_pc;

  logic        is_branch;
  logic        is_jal;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic [31:0] b_target;
  logic [31:0] j_target;
  logic [31:0] seq_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  assign bus.imem_addr_o = pc;
  assign bus.branch_pc_o = pc;

  // Decode the fetched word and form the predicted next PC
  always_comb begin
    is_branch = (bus.instr_i[6:0] == 7'b1100011);
    is_jal    = (bus.instr_i[6:0] == 7'b1101111);
    b_imm     = {{20{bus.instr_i[31]}}, bus.instr_i[7], bus.instr_i[30:25],
                 bus.instr_i[11:8], 1'b0};
    j_imm     = {{12{bus.instr_i[31]}}, bus.instr_i[19:12], bus.instr_i[20],
                 bus.instr_i[30:21], 1'b0};
    j_target  = (pc + j_imm) & 32'hFFFF_FFFE;
    b_target  = USE_BTB_TARGET ? (bus.pred_dest_i & 32'hFFFF_FFFE)
                               : ((pc + b_imm) & 32'hFFFF_FFFE);
    seq_pc    = pc + 32'd4;
    pred_taken  = is_jal | (is_branch & bus.pred_take_i);
    pred_target = seq_pc;
    if (is_jal) begin
      pred_target = j_target;
    end else if (is_branch && bus.pred_take_i) begin
      pred_target = b_target;
    end
  end

  // Fetch control FSM, PC and IF/ID register.
  // RUN and MEM_WAIT share one transition body: MEM_WAIT only differs in
  // that its entry was caused by a busy memory, and its exit on data return
  // is exactly a RUN capture. A redirect while memory is busy is parked in
  // pending_pc so the outstanding fetch address never changes mid-request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= RUN;
      pc                  <= RESET_PC;
      pending_pc          <= '0;
      bus.if_valid_o       <= 1'b0;
      bus.if_pc_o          <= '0;
      bus.if_instr_o       <= '0;
      bus.if_pred_taken_o  <= 1'b0;
      bus.if_pred_target_o <= '0;
    end else begin
      case (state)
        RUN, MEM_WAIT: begin
          if (bus.redirect_i) begin
            bus.if_valid_o <= 1'b0;
            if (bus.imem_stall_i) begin
              pending_pc <= bus.redirect_pc_i;
              state      <= MEM_WAIT_REDIR;
            end else begin
              pc    <= bus.redirect_pc_i;
              state <= RUN;
            end
          end else if (bus.imem_stall_i) begin
            if (!bus.stall_i) bus.if_valid_o <= 1'b0;
            state <= MEM_WAIT;
          end else begin
            state <= RUN;
            if (!bus.stall_i) begin
              bus.if_valid_o       <= 1'b1;
              bus.if_pc_o          <= pc;
              bus.if_instr_o       <= bus.instr_i;
              bus.if_pred_taken_o  <= pred_taken;
              bus.if_pred_target_o <= pred_target;
              pc                   <= pred_target;
            end
          end
        end
        MEM_WAIT_REDIR: begin
          bus.if_valid_o <= 1'b0;
          if (bus.redirect_i) pending_pc <= bus.redirect_pc_i;
          if (!bus.imem_stall_i) begin
            pc    <= bus.redirect_i ? bus.redirect_pc_i : pending_pc;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: two instances (computed branch target with
// RESET_PC=0, predictor-supplied target with RESET_PC=0x1000) driven with the
// same directed and random stimulus and checked against a behavioural model.
module tb_fetch_pc_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] instr, pred_dest, redirect_pc;
  logic        imem_stall, pred_take, stall, redirect;

  fetch_pc_unit_if bus0 ();
  fetch_pc_unit_if bus1 ();

  assign bus0.instr_i = instr;        assign bus1.instr_i = instr;
  assign bus0.imem_stall_i = imem_stall; assign bus1.imem_stall_i = imem_stall;
  assign bus0.pred_take_i = pred_take;  assign bus1.pred_take_i = pred_take;
  assign bus0.pred_dest_i = pred_dest;  assign bus1.pred_dest_i = pred_dest;
  assign bus0.stall_i = stall;          assign bus1.stall_i = stall;
  assign bus0.redirect_i = redirect;    assign bus1.redirect_i = redirect;
  assign bus0.redirect_pc_i = redirect_pc; assign bus1.redirect_pc_i = redirect_pc;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .USE_BTB_TARGET(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  fetch_pc_unit #(.RESET_PC(32'h0000_1000), .USE_BTB_TARGET(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  int tests = 0;
  int fails = 0;

  // Model: PC, an optional deferred redirect, and the IF/ID contents
  logic [31:0] m_pc [2];
  logic        m_pend [2];
  logic [31:0] m_pend_pc [2];
  logic        m_v [2];
  logic [31:0] m_ipc [2];
  logic [31:0] m_iins [2];
  logic        m_ptk [2];
  logic [31:0] m_ptgt [2];

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ_P40 = 32'h0400_0063;  // beq x0,x0,+0x40

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic        tk;
      logic [31:0] tgt;
      tk  = 1'b0;
      tgt = m_pc[k] + 32'd4;
      if (instr[6:0] == 7'h6F) begin
        tk  = 1'b1;
        tgt = (m_pc[k] + imm_j(instr)) & ~32'd1;
      end else if (instr[6:0] == 7'h63 && pred_take) begin
        tk  = 1'b1;
        tgt = (k == 1) ? (pred_dest & ~32'd1) : ((m_pc[k] + imm_b(instr)) & ~32'd1);
      end
      if (rst) begin
        m_pc[k] = (k == 1) ? 32'h1000 : 32'h0;
        m_pend[k] = 1'b0; m_pend_pc[k] = '0; m_v[k] = 1'b0;
        m_ipc[k] = '0; m_iins[k] = '0; m_ptk[k] = 1'b0; m_ptgt[k] = '0;
      end else if (redirect) begin
        m_v[k] = 1'b0;
        if (imem_stall) begin
          m_pend[k] = 1'b1; m_pend_pc[k] = redirect_pc;
        end else begin
          m_pend[k] = 1'b0; m_pc[k] = redirect_pc;
        end
      end else if (m_pend[k]) begin
        m_v[k] = 1'b0;
        if (!imem_stall) begin
          m_pend[k] = 1'b0; m_pc[k] = m_pend_pc[k];
        end
      end else if (imem_stall) begin
        if (!stall) m_v[k] = 1'b0;
      end else if (!stall) begin
        m_v[k] = 1'b1; m_ipc[k] = m_pc[k]; m_iins[k] = instr;
        m_ptk[k] = tk; m_ptgt[k] = tgt; m_pc[k] = tgt;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input int k, input logic [31:0] addr, input logic [31:0] bpc,
                     input logic v, input logic [31:0] ipc, input logic [31:0] iins,
                     input logic ptk, input logic [31:0] ptgt);
    check($sformatf("imem_addr%0d", k), addr, m_pc[k]);
    check($sformatf("branch_pc%0d", k), bpc, m_pc[k]);
    check($sformatf("if_valid%0d", k), {31'd0, v}, {31'd0, m_v[k]});
    if (m_v[k]) begin
      check($sformatf("if_pc%0d", k), ipc, m_ipc[k]);
      check($sformatf("if_instr%0d", k), iins, m_iins[k]);
      check($sformatf("if_pred_taken%0d", k), {31'd0, ptk}, {31'd0, m_ptk[k]});
      check($sformatf("if_pred_target%0d", k), ptgt, m_ptgt[k]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cmp(0, bus0.imem_addr_o, bus0.branch_pc_o, bus0.if_valid_o, bus0.if_pc_o,
        bus0.if_instr_o, bus0.if_pred_taken_o, bus0.if_pred_target_o);
    cmp(1, bus1.imem_addr_o, bus1.branch_pc_o, bus1.if_valid_o, bus1.if_pc_o,
        bus1.if_instr_o, bus1.if_pred_taken_o, bus1.if_pred_target_o);
  endtask

  task automatic idle();
    instr = NOP; imem_stall = 1'b0; pred_take = 1'b0; pred_dest = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
  endtask

  task automatic jump_to(input logic [31:0] a);
    idle(); redirect = 1'b1; redirect_pc = a;
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    // Reset and sequential NOP stream
    rst = 1'b1; idle();
    tick(); tick();
    check("rst_addr0", bus0.imem_addr_o, 32'h0);
    check("rst_addr1", bus1.imem_addr_o, 32'h1000);
    check("rst_valid", {31'd0, bus0.if_valid_o}, 32'd0);
    check("rst_ptgt", bus0.if_pred_target_o, 32'h0);
    rst = 1'b0;
    tick();
    check("nop_addr4", bus0.imem_addr_o, 32'h4);
    check("nop_valid", {31'd0, bus0.if_valid_o}, 32'd1);
    tick(); check("nop_addr8", bus0.imem_addr_o, 32'h8);
    tick(); check("nop_addrC", bus0.imem_addr_o, 32'hC);

    // Predicted-taken and not-taken BEQ at 0x100
    jump_to(32'h100);
    check("redir_valid", {31'd0, bus0.if_valid_o}, 32'd0);
    instr = BEQ_P40; pred_take = 1'b1; pred_dest = 32'h301;
    tick();
    check("beq_taken_pc", bus0.imem_addr_o, 32'h140);
    check("beq_taken_flag", {31'd0, bus0.if_pred_taken_o}, 32'd1);
    check("beq_taken_tgt", bus0.if_pred_target_o, 32'h140);
    jump_to(32'h100);
    instr = BEQ_P40; pred_take = 1'b0;
    tick();
    check("beq_nt_pc", bus0.imem_addr_o, 32'h104);
    check("beq_nt_tgt", bus0.if_pred_target_o, 32'h104);

    // Predictor-supplied target at 0x200
    jump_to(32'h200);
    instr = BEQ_P40; pred_take = 1'b1; pred_dest = 32'h301;
    tick();
    check("btb_pc", bus1.imem_addr_o, 32'h300);
    check("nobtb_pc", bus0.imem_addr_o, 32'h240);

    // Busy memory at 0x80 with a redirect arriving mid-wait
    jump_to(32'h80);
    imem_stall = 1'b1;
    tick(); check("wait1_addr", bus0.imem_addr_o, 32'h80);
    redirect = 1'b1; redirect_pc = 32'h400;
    tick(); check("wait2_addr", bus0.imem_addr_o, 32'h80);
    redirect = 1'b0;
    tick(); check("wait3_addr", bus0.imem_addr_o, 32'h80);
    imem_stall = 1'b0;
    tick();
    check("wait_redir_pc", bus0.imem_addr_o, 32'h400);
    check("wait_redir_valid", {31'd0, bus0.if_valid_o}, 32'd0);

    // Redirect overrides hazard stall
    tick();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h10;
    tick();
    check("stall_redir_pc", bus0.imem_addr_o, 32'h10);
    check("stall_redir_valid", {31'd0, bus0.if_valid_o}, 32'd0);

    // PC wrap-around
    jump_to(32'hFFFF_FFFC);
    tick();
    check("wrap_pc", bus0.imem_addr_o, 32'h0);

    // Reset in the middle of a redirected wait
    idle(); imem_stall = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h500;
    tick();
    redirect = 1'b0; rst = 1'b1;
    tick();
    check("rst_wait_addr", bus0.imem_addr_o, 32'h0);
    rst = 1'b0; imem_stall = 1'b0;
    tick();
    check("rst_wait_next", bus0.imem_addr_o, 32'h4);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int unsigned sel;
      sel = $urandom_range(0, 3);
      instr = $urandom;
      if (sel == 0) instr[6:0] = 7'h63;
      else if (sel == 1) instr[6:0] = 7'h6F;
      pred_take   = 1'($urandom_range(0, 1));
      pred_dest   = $urandom;
      imem_stall  = ($urandom_range(0, 3) == 0);
      stall       = ($urandom_range(0, 4) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      rst         = ($urandom_range(0, 96) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
